cla_seq_adder: RTL and testbench
================================

CLA_SEQ_ADDER -- requirements
Module: cla_seq_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width; legal values are multiples of 4 in the range 4..64, with NSLICE = WIDTH/4.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: operands and mode are valid.
REQ-005 SHALL have port in_ready, output, 1 bit: block can accept an operation.
REQ-006 SHALL have port a, input, WIDTH bits: operand A.
REQ-007 SHALL have port b, input, WIDTH bits: operand B.
REQ-008 SHALL have port cin, input, 1 bit: carry-in for add, borrow-in for subtract.
REQ-009 SHALL have port sub, input, 1 bit: mode; 0 = add, 1 = subtract.
REQ-010 SHALL have port out_valid, output, 1 bit: result is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-012 SHALL have port sum, output, WIDTH bits: result.
REQ-013 SHALL have port cout, output, 1 bit: carry-out; for subtract it is the inverted borrow.
REQ-014 SHALL have port ovf, output, 1 bit: two's-complement signed overflow.
REQ-015 SHALL have port busy, output, 1 bit: high while in state RUN.

Function
REQ-016 SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-017 SHALL drive in_ready = (state==IDLE) | (state==DONE & out_ready).
REQ-018 SHALL accept an operation on any edge with in_valid & in_ready.
REQ-019 On acceptance, SHALL capture opA = a, opB = sub ? ~b : b and carry = sub ? ~cin : cin.
REQ-020 On acceptance, SHALL clear the slice index to 0 and enter RUN.
REQ-021 SHALL therefore compute add as a+b+cin and subtract as a-b-cin = a+~b+!cin.
REQ-022 In RUN, each edge SHALL process one 4-bit slice k (bits 4k+3..4k) with a carry-lookahead group.
REQ-023 The lookahead group SHALL compute g_i = a_i&b_i and p_i = a_i^b_i.
REQ-024 The lookahead group SHALL flatten carries c1..c4 from g, p and the carry register, with no ripple within the slice.
REQ-025 Each RUN edge SHALL write sum[4k+3:4k], load the carry register with c4 and increment k.
REQ-026 On the edge that processes slice NSLICE-1, SHALL enter DONE.
REQ-027 On that same edge, SHALL set cout = c4 of the final slice.
REQ-028 On that same edge, SHALL set ovf = c3^c4 of the final slice.
REQ-029 Latency SHALL be exactly NSLICE cycles from the accept edge to out_valid high (4 cycles for WIDTH=16, 1 cycle for WIDTH=4).
REQ-030 out_valid SHALL be high only in DONE.
REQ-031 sum, cout and ovf SHALL hold stable while out_valid=1 & out_ready=0, for any number of cycles.
REQ-032 In DONE with out_ready=1 and in_valid=0, SHALL go to IDLE.
REQ-033 In DONE with out_ready=1 and in_valid=1 on the same edge, SHALL accept the new operation and go directly to RUN, with no idle bubble.
REQ-034 in_valid in RUN SHALL be ignored, with no capture and no state change.
REQ-035 sum bits not yet written in RUN SHALL keep their previous values.
REQ-036 sum, cout and ovf SHALL be observed only when out_valid=1.

Reset
REQ-037 While rst_n=0, SHALL force state IDLE, sum=0, cout=0, ovf=0, out_valid=0, busy=0, in_ready=1, carry register=0 and slice index=0, regardless of clk.
REQ-038 Reset asserted mid-RUN or in DONE SHALL abandon the operation, with no result ever presented.
REQ-039 After rst_n deasserts, the first accept SHALL be possible on the first rising clk edge.

Verification
REQ-040 WIDTH=16, add: a=0x0009, b=0x000C, cin=0 -> out_valid 4 cycles after accept; sum=0x0015, cout=0, ovf=0; busy high for exactly 4 cycles.
REQ-041 WIDTH=16, add: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0; a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1.
REQ-042 WIDTH=16, subtract: a=0x0005, b=0x0006, cin=0 -> sum=0xFFFF, cout=0, ovf=0; a=0x8000, b=0x0001, cin=0 -> sum=0x7FFF, cout=1, ovf=1.
REQ-043 Backpressure: out_ready held 0 for 10 cycles in DONE -> out_valid and all results stable; then out_ready=1 with in_valid=1 (a=0x1234, b=0x1111) -> first result retired, new op accepted on the same edge, sum=0x2345 after 4 cycles.
REQ-044 Reset mid-RUN: rst_n=0 on the 2nd RUN cycle -> immediately out_valid=0, busy=0, sum=0, in_ready=1; next op (a=0x0003, b=0x0003) gives sum=0x0006.
REQ-045 WIDTH=4 instance: a=0x9, b=0xC, cin=0 -> sum=0x5, cout=1 after 1 cycle; a=0xF, b=0xF -> sum=0xE, cout=1; a=0x9, b=0xA, cin=1 -> sum=0x4, cout=1.

Source files
------------

// File: rtl/cla_seq_adder.sv
// Sequential adder/subtractor: one 4-bit carry-lookahead slice is processed
// per clock, and the result is presented through a valid/ready handshake.
module cla_seq_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned NSLICE = WIDTH / 4;
  localparam int unsigned IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  opa_q;
  logic [WIDTH-1:0]  opb_q;
  logic              carry_q;
  logic [IDXW-1:0]   idx_q;
  logic [WIDTH-1:0]  sum_q;
  logic              cout_q;
  logic              ovf_q;

  logic              accept_c;
  logic              last_c;
  logic [3:0]        sa_c;
  logic [3:0]        sb_c;
  logic [3:0]        g_c;
  logic [3:0]        p_c;
  logic [4:0]        c_c;
  logic [3:0]        s_c;
  logic [WIDTH-1:0]  sum_d;

  assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign accept_c  = in_valid & in_ready;
  assign last_c    = (idx_q == IDXW'(NSLICE - 1));
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

  // Select the active slice, flatten its carries, and merge it into the sum
  always_comb begin
    sa_c  = 4'd0;
    sb_c  = 4'd0;
    for (int j = 0; j < int'(NSLICE); j++) begin
      if (idx_q == IDXW'(j)) begin
        sa_c = opa_q[4*j +: 4];
        sb_c = opb_q[4*j +: 4];
      end
    end
    g_c    = sa_c & sb_c;
    p_c    = sa_c ^ sb_c;
    c_c[0] = carry_q;
    c_c[1] = g_c[0] | (p_c[0] & carry_q);
    c_c[2] = g_c[1] | (p_c[1] & g_c[0]) | (p_c[1] & p_c[0] & carry_q);
    c_c[3] = g_c[2] | (p_c[2] & g_c[1]) | (p_c[2] & p_c[1] & g_c[0])
           | (p_c[2] & p_c[1] & p_c[0] & carry_q);
    c_c[4] = g_c[3] | (p_c[3] & g_c[2]) | (p_c[3] & p_c[2] & g_c[1])
           | (p_c[3] & p_c[2] & p_c[1] & g_c[0])
           | (p_c[3] & p_c[2] & p_c[1] & p_c[0] & carry_q);
    s_c    = p_c ^ c_c[3:0];
    sum_d  = sum_q;
    for (int j = 0; j < int'(NSLICE); j++) begin
      if (idx_q == IDXW'(j)) begin
        sum_d[4*j +: 4] = s_c;
      end
    end
  end

  // Control FSM and datapath registers; subtract is folded into operand capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept_c) begin
      state_q <= RUN;
      opa_q   <= a;
      opb_q   <= sub ? ~b : b;
      carry_q <= sub ? ~cin : cin;
      idx_q   <= '0;
    end else begin
      case (state_q)
        RUN: begin
          sum_q   <= sum_d;
          carry_q <= c_c[4];
          idx_q   <= idx_q + IDXW'(1);
          if (last_c) begin
            state_q <= DONE;
            cout_q  <= c_c[4];
            ovf_q   <= c_c[3] ^ c_c[4];
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed bench for cla_seq_adder: a WIDTH=16 and a WIDTH=4 instance.
module tb_cla_seq_adder;

  logic        clk;
  logic        rst_n;

  logic        in_valid16, in_ready16, cin16, sub16, out_valid16, out_ready16;
  logic        cout16, ovf16, busy16;
  logic [15:0] a16, b16, sum16;

  logic        in_valid4, in_ready4, cin4, sub4, out_valid4, out_ready4;
  logic        cout4, ovf4, busy4;
  logic [3:0]  a4, b4, sum4;

  int total;
  int bad;

  cla_seq_adder #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .cin(cin16), .sub(sub16), .out_valid(out_valid16),
    .out_ready(out_ready16), .sum(sum16), .cout(cout16), .ovf(ovf16), .busy(busy16)
  );

  cla_seq_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4), .sub(sub4), .out_valid(out_valid4),
    .out_ready(out_ready4), .sum(sum4), .cout(cout4), .ovf(ovf4), .busy(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one op into the 16-bit instance, count edges until out_valid
  task automatic run_op16(input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input logic s, input bit hold,
                          output int lat, output int bcnt);
    a16 = a; b16 = b; cin16 = ci; sub16 = s; in_valid16 = 1'b1;
    @(posedge clk); #1;
    if (hold) a16 = 16'hFFFF;
    else in_valid16 = 1'b0;
    lat = 0; bcnt = 0;
    while (out_valid16 !== 1'b1 && lat < 20) begin
      if (busy16 === 1'b1) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op4(input logic [3:0] a, input logic [3:0] b,
                         input logic ci, output int lat);
    a4 = a; b4 = b; cin4 = ci; sub4 = 1'b0; in_valid4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    lat = 0;
    while (out_valid4 !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic retire16();
    out_ready16 = 1'b1;
    @(posedge clk); #1;
    out_ready16 = 1'b0;
  endtask

  task automatic retire4();
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    out_ready4 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    repeat (2) @(posedge clk);
    #1;
    total++; if (sum16 !== 16'h0000) begin bad++; $display("FAIL reset_sum got=%h exp=0000", sum16); end
    total++; if (cout16 !== 1'b0) begin bad++; $display("FAIL reset_cout got=%b exp=0", cout16); end
    total++; if (ovf16 !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf16); end
    total++; if (out_valid16 !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid16); end
    total++; if (busy16 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy16); end
    total++; if (in_ready16 !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready16); end
    total++; if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0) begin
      bad++; $display("FAIL reset_w4 in_ready=%b out_valid=%b exp=1/0", in_ready4, out_valid4);
    end
    #2 rst_n = 1'b1;
  endtask

  task automatic test_add();
    logic [15:0] va [3] = '{16'h0009, 16'hFFFF, 16'h7FFF};
    logic [15:0] vb [3] = '{16'h000C, 16'h0001, 16'h0001};
    logic [15:0] es [3] = '{16'h0015, 16'h0000, 16'h8000};
    logic        ec [3] = '{1'b0, 1'b1, 1'b0};
    logic        eo [3] = '{1'b0, 1'b0, 1'b1};
    int lat, bcnt;
    for (int i = 0; i < 3; i++) begin
      run_op16(va[i], vb[i], 1'b0, 1'b0, 1'b0, lat, bcnt);
      total++; if (lat != 4) begin bad++; $display("FAIL add%0d_latency got=%0d exp=4", i, lat); end
      total++; if (bcnt != 4) begin bad++; $display("FAIL add%0d_busy_cycles got=%0d exp=4", i, bcnt); end
      total++; if (sum16 !== es[i]) begin bad++; $display("FAIL add%0d_sum got=%h exp=%h", i, sum16, es[i]); end
      total++; if (cout16 !== ec[i]) begin bad++; $display("FAIL add%0d_cout got=%b exp=%b", i, cout16, ec[i]); end
      total++; if (ovf16 !== eo[i]) begin bad++; $display("FAIL add%0d_ovf got=%b exp=%b", i, ovf16, eo[i]); end
      retire16();
      total++; if (out_valid16 !== 1'b0 || in_ready16 !== 1'b1) begin
        bad++; $display("FAIL add%0d_retire out_valid=%b in_ready=%b exp=0/1", i, out_valid16, in_ready16);
      end
    end
  endtask

  task automatic test_sub();
    logic [15:0] va [2] = '{16'h0005, 16'h8000};
    logic [15:0] vb [2] = '{16'h0006, 16'h0001};
    logic [15:0] es [2] = '{16'hFFFF, 16'h7FFF};
    logic        ec [2] = '{1'b0, 1'b1};
    logic        eo [2] = '{1'b0, 1'b1};
    int lat, bcnt;
    for (int i = 0; i < 2; i++) begin
      run_op16(va[i], vb[i], 1'b0, 1'b1, 1'b0, lat, bcnt);
      total++; if (lat != 4) begin bad++; $display("FAIL sub%0d_latency got=%0d exp=4", i, lat); end
      total++; if (sum16 !== es[i]) begin bad++; $display("FAIL sub%0d_sum got=%h exp=%h", i, sum16, es[i]); end
      total++; if (cout16 !== ec[i]) begin bad++; $display("FAIL sub%0d_cout got=%b exp=%b", i, cout16, ec[i]); end
      total++; if (ovf16 !== eo[i]) begin bad++; $display("FAIL sub%0d_ovf got=%b exp=%b", i, ovf16, eo[i]); end
      retire16();
    end
  endtask

  task automatic test_ignore_in_run();
    int lat, bcnt;
    run_op16(16'h0100, 16'h0020, 1'b0, 1'b0, 1'b1, lat, bcnt);
    total++; if (lat != 4) begin bad++; $display("FAIL ignore_latency got=%0d exp=4", lat); end
    total++; if (sum16 !== 16'h0120) begin bad++; $display("FAIL ignore_sum got=%h exp=0120", sum16); end
    @(posedge clk); #1;
    total++; if (out_valid16 !== 1'b1 || sum16 !== 16'h0120) begin
      bad++; $display("FAIL ignore_done_hold out_valid=%b sum=%h exp=1/0120", out_valid16, sum16);
    end
    in_valid16 = 1'b0;
    retire16();
  endtask

  task automatic test_back_to_back();
    int lat, bcnt;
    run_op16(16'h0009, 16'h000C, 1'b0, 1'b0, 1'b0, lat, bcnt);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      total++; if (out_valid16 !== 1'b1 || sum16 !== 16'h0015 || cout16 !== 1'b0 || ovf16 !== 1'b0) begin
        bad++; $display("FAIL bp_hold%0d out_valid=%b sum=%h cout=%b ovf=%b exp=1/0015/0/0",
                        i, out_valid16, sum16, cout16, ovf16);
      end
    end
    total++; if (in_ready16 !== 1'b0) begin bad++; $display("FAIL bp_in_ready_stalled got=%b exp=0", in_ready16); end
    a16 = 16'h1234; b16 = 16'h1111; cin16 = 1'b0; sub16 = 1'b0;
    in_valid16 = 1'b1; out_ready16 = 1'b1;
    #1;
    total++; if (in_ready16 !== 1'b1) begin bad++; $display("FAIL bp_in_ready_release got=%b exp=1", in_ready16); end
    @(posedge clk); #1;
    in_valid16 = 1'b0; out_ready16 = 1'b0;
    total++; if (busy16 !== 1'b1 || out_valid16 !== 1'b0) begin
      bad++; $display("FAIL b2b_no_bubble busy=%b out_valid=%b exp=1/0", busy16, out_valid16);
    end
    lat = 0;
    while (out_valid16 !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    total++; if (lat != 4) begin bad++; $display("FAIL b2b_latency got=%0d exp=4", lat); end
    total++; if (sum16 !== 16'h2345) begin bad++; $display("FAIL b2b_sum got=%h exp=2345", sum16); end
    retire16();
  endtask

  task automatic test_reset_mid_run();
    int lat, bcnt;
    a16 = 16'h1111; b16 = 16'h2222; cin16 = 1'b0; sub16 = 1'b0; in_valid16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid16 !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid16); end
    total++; if (busy16 !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy16); end
    total++; if (sum16 !== 16'h0000) begin bad++; $display("FAIL midrst_sum got=%h exp=0000", sum16); end
    total++; if (in_ready16 !== 1'b1) begin bad++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready16); end
    @(posedge clk); #2;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      total++; if (out_valid16 !== 1'b0) begin bad++; $display("FAIL midrst_no_result%0d got=%b exp=0", i, out_valid16); end
    end
    run_op16(16'h0003, 16'h0003, 1'b0, 1'b0, 1'b0, lat, bcnt);
    total++; if (lat != 4) begin bad++; $display("FAIL midrst_next_latency got=%0d exp=4", lat); end
    total++; if (sum16 !== 16'h0006) begin bad++; $display("FAIL midrst_next_sum got=%h exp=0006", sum16); end
    retire16();
  endtask

  task automatic test_w4();
    logic [3:0] va [3] = '{4'h9, 4'hF, 4'h9};
    logic [3:0] vb [3] = '{4'hC, 4'hF, 4'hA};
    logic       vc [3] = '{1'b0, 1'b0, 1'b1};
    logic [3:0] es [3] = '{4'h5, 4'hE, 4'h4};
    logic       eo [3] = '{1'b1, 1'b0, 1'b1};
    int lat;
    for (int i = 0; i < 3; i++) begin
      run_op4(va[i], vb[i], vc[i], lat);
      total++; if (lat != 1) begin bad++; $display("FAIL w4_%0d_latency got=%0d exp=1", i, lat); end
      total++; if (sum4 !== es[i]) begin bad++; $display("FAIL w4_%0d_sum got=%h exp=%h", i, sum4, es[i]); end
      total++; if (cout4 !== 1'b1) begin bad++; $display("FAIL w4_%0d_cout got=%b exp=1", i, cout4); end
      total++; if (ovf4 !== eo[i]) begin bad++; $display("FAIL w4_%0d_ovf got=%b exp=%b", i, ovf4, eo[i]); end
      retire4();
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0;
    in_valid16 = 1'b0; out_ready16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0;
    in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_ignore_in_run();
    test_back_to_back();
    test_reset_mid_run();
    test_w4();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
